// File: rtl/mult_share_ctrl.sv
// Shared shift-add multiplier: arbitrates two requesters onto one datapath, one multiplier bit per cycle.
// The product is held on the result port until accepted; grant priority flips to the other requester after each result.
module mult_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [2*WIDTH-1:0] res_p,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gnt0, gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    // A lone valid requester wins; on contention the prio requester wins.
    gnt0 = req0_valid && (!req1_valid || !prio_q);
    gnt1 = req1_valid && (!req0_valid || prio_q);

    case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          id_d    = gnt1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (b_q[cnt_q]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          prio_d  = ~id_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign res_valid = (state_q == DONE);
  assign res_p     = acc_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl (WIDTH=4) with hand-computed products and cycle-exact latency checks.
module tb_mult_share_ctrl;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           res_valid, res_ready, res_id, busy;
  logic [2*W-1:0] res_p;

  int checks = 0;
  int errors = 0;

  mult_share_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_p      (res_p),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_p"}, res_p, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    res_ready = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // req0 3x3 alone, res_ready low until the result appears
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd3;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t1_ready_drop", req0_ready, 0);
    for (int i = 1; i < W; i++) begin
      chk("t1_calc_busy", busy, 1);
      tick();
      chk("t1_calc_no_res", res_valid, 0);
    end
    tick();
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_p", res_p, 9);
    chk("t1_res_id", res_id, 0);
    chk("t1_busy_done", busy, 1);
    res_ready = 1'b1;
    tick();
    chk("t1_back_idle_busy", busy, 0);
    chk("t1_back_idle_valid", res_valid, 0);

    // req1 15x15 alone with res_ready tied high (also pulsing while res_valid is low)
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
    #1;
    chk("t2_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < W - 1; i++) tick();
    chk("t2_no_early_res", res_valid, 0);
    tick();
    chk("t2_res_valid", res_valid, 1);
    chk("t2_res_p", res_p, 225);
    chk("t2_res_id", res_id, 1);
    // next request queued during DONE: not accepted until IDLE
    req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd13;
    #1;
    chk("t2_no_ready_in_done", req0_ready, 0);
    tick();
    chk("t2_idle_after_done", busy, 0);
    chk("t2_next_ready", req0_ready, 1);
    tick();
    // req0 0x13 accepted 6 cycles after previous handshake; operands change afterwards
    req0_valid = 1'b0; req0_a = 4'd15; req0_b = 4'd15;
    chk("t6_busy", busy, 1);
    for (int i = 0; i < W - 1; i++) tick();
    chk("t6_no_early_res", res_valid, 0);
    tick();
    chk("t6_res_valid", res_valid, 1);
    chk("t6_res_p", res_p, 0);
    chk("t6_res_id", res_id, 0);
    tick();
    chk("t6_idle", busy, 0);

    // reset restores prio=0, then both requesters continuously valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    req0_valid = 1'b1; req0_a = 4'd5;  req0_b = 4'd7;
    req1_valid = 1'b1; req1_a = 4'd12; req1_b = 4'd11;
    #1;
    chk("t3_first_gnt0", req0_ready, 1);
    chk("t3_first_gnt1", req1_ready, 0);
    tick();
    for (int i = 0; i < W; i++) tick();
    chk("t3_r1_valid", res_valid, 1);
    chk("t3_r1_id", res_id, 0);
    chk("t3_r1_p", res_p, 35);
    chk("t3_done_ready0", req0_ready, 0);
    chk("t3_done_ready1", req1_ready, 0);
    tick();
    chk("t3_second_gnt0", req0_ready, 0);
    chk("t3_second_gnt1", req1_ready, 1);
    tick();
    for (int i = 0; i < W; i++) tick();
    chk("t3_r2_id", res_id, 1);
    chk("t3_r2_p", res_p, 132);
    tick();
    chk("t3_third_gnt0", req0_ready, 1);
    chk("t3_third_gnt1", req1_ready, 0);
    tick();
    for (int i = 0; i < W; i++) tick();
    chk("t3_r3_id", res_id, 0);
    chk("t3_r3_p", res_p, 35);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b0;

    // req0 9x6 with res_ready held low for 5 DONE cycles
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd6;
    #1;
    chk("t4_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_p", res_p, 54);
      chk("t4_hold_id", res_id, 0);
      chk("t4_hold_ready0", req0_ready, 0);
      chk("t4_hold_ready1", req1_ready, 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("t4_release_valid", res_valid, 0);
    chk("t4_release_busy", busy, 0);
    res_ready = 1'b0;

    // async reset during the 2nd CALC cycle of 13x13
    req0_valid = 1'b1; req0_a = 4'd13; req0_b = 4'd13;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("t5_in_calc", busy, 1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("t5_abort");
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
    #1;
    chk("t5_prio0_gnt0", req0_ready, 1);
    chk("t5_prio0_gnt1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < W - 1; i++) begin
      tick();
      chk("t5_no_stale_res", res_valid, 0);
    end
    tick();
    chk("t5_res_valid", res_valid, 1);
    chk("t5_res_p", res_p, 6);
    chk("t5_res_id", res_id, 0);
    tick();
    chk("t5_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Shared sequential multiplier controller: arbitrates two requesters onto one shift-add multiply datapath and returns each product on a single result port. Operands are captured on a valid/ready handshake. The product is built one multiplier bit per cycle, then held until the consumer accepts it. It replaces per-requester combinational multipliers where area matters more than latency.

## Interface
- WIDTH, 4, operand width in bits (≥2); product is 2*WIDTH bits

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 multiplicand / multiplier (unsigned)
- req1_valid  in  1  requester 1 has operands
- req1_ready  out  1  requester 1 operands accepted this cycle
- req1_a, req1_b  in  WIDTH  requester 1 multiplicand / multiplier (unsigned)
- res_valid  out  1  product available
- res_ready  in  1  consumer accepts product
- res_id  out  1  requester that owns res_p
- res_p  out  2*WIDTH  unsigned product
- busy  out  1  high in CALC or DONE

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - grant = the only valid requester; if both are valid, grant = prio.
  - reqN_ready = 1 only for the granted requester; both readys are 0 if neither is valid.
  - On a handshake (valid & ready):
    - capture a, b and id.
    - Clear acc (2*WIDTH bits) and cnt.
    - Go to CALC.
- CALC, one edge per bit:
  - If b[cnt] = 1: acc += a << cnt.
  - Then cnt += 1.
  - The edge that processes cnt = WIDTH-1 moves to DONE.
- DONE:
  - res_valid = 1; res_p = acc; res_id = captured id.
  - All outputs hold stable while res_ready = 0.
  - On res_valid & res_ready: go to IDLE and set prio = ~res_id.
- Arithmetic:
  - Unsigned only.
  - acc never overflows, since max (2^W−1)^2 < 2^(2W).
  - No truncation of the product.
- Requester rules:
  - A requester holds valid and operands stable until it sees ready.
  - A requester that is not granted may change its operands freely.
  - Operand changes after the handshake have no effect on the product.
- Only one operation is in flight; no request is accepted in CALC or DONE.
- Outputs are registered or decoded from registered state. Exception: reqN_ready also depends on the reqN_valid inputs.

## Timing
- Reset values: state = IDLE, prio = 0, acc = 0, cnt = 0, req0_ready = req1_ready = 0, res_valid = 0, res_id = 0, res_p = 0, busy = 0.
- Reset asserted mid-operation (CALC or DONE) aborts immediately and asynchronously. The in-flight result is discarded and never presented.
- Latency: handshake at edge E puts the block in CALC from E. res_valid rises after edge E+WIDTH (WIDTH cycles in CALC).
- With res_ready tied high: DONE lasts 1 cycle, then IDLE accepts at the next edge. Sustained throughput is one product per WIDTH+2 cycles.
- Simultaneous events:
  - Both valid in the same IDLE cycle: only the prio requester gets ready.
  - The other requester is served in the next IDLE, provided it is still valid.
  - With both continuously valid, grants strictly alternate 0, 1, 0, 1, …
- A valid that rises while busy is only considered once the block returns to IDLE.
- A res_ready pulse while res_valid = 0 is ignored.
- Zero operands still take the full WIDTH CALC cycles (no early exit).

## Test plan
- WIDTH=4, reset then req0 a=3 b=3 alone -> req0_ready=1 for one cycle; res_valid after 4 CALC edges; res_p=9, res_id=0, busy=1 throughout.
- req1 a=15 b=15 alone, res_ready=1 -> res_p=225, res_id=1; next IDLE accepts at the edge after the DONE handshake (6-cycle period).
- Both valid from reset, continuously: req0 (5×7) and req1 (12×11) -> results in order id 0 then 1, then 0 again; res_p=35, then 132, with strict alternation.
- res_ready held low for 5 cycles in DONE with req0 a=9 b=6 -> res_valid, res_p=54 and res_id stable all 5 cycles; no reqN_ready asserted; IDLE only after res_ready=1.
- Assert rst during the 2nd CALC cycle of 13×13 -> all outputs go to 0 immediately. After release: prio=0 and no res_valid for the aborted op. A fresh 2×3 request returns 6.
- req0 a=0 b=13 -> res_p=0 after exactly 4 CALC cycles; changing req0_a/b after the handshake does not alter the result.
